// File: rtl/aes_cipher_out_packer.sv
// Packs the byte-serial AES ciphertext stream into WORD_BYTES-wide words and
// buffers them in a first-word fall-through FIFO with message-boundary tagging.
module aes_cipher_out_packer #(
  parameter int WORD_BYTES = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              new_message,
  input  logic                              end_message,
  input  logic                              valid_in,
  input  logic [7:0]                        data_in,
  output logic [8*WORD_BYTES-1:0]           word_out,
  output logic                              word_valid,
  input  logic                              word_ready,
  output logic                              word_last,
  output logic [$clog2(WORD_BYTES+1)-1:0]   word_bytes,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              overflow
);

  localparam int CW = $clog2(WORD_BYTES + 1);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int WW = 8 * WORD_BYTES;

  typedef struct packed {
    logic [WW-1:0] data;
    logic [CW-1:0] bytes;
    logic          last;
  } entry_t;

  entry_t        mem_q [FIFO_DEPTH];
  entry_t        mem_d [FIFO_DEPTH];
  entry_t        head;
  logic [CW-1:0] count_q, count_d, cnt_base, cnt_after;
  logic [WW-1:0] pack_q, pack_d, pack_next;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          full_lane, push, pop, do_push;

  // new_message clears first, then the byte lands, then end_message decides the push
  always_comb begin
    cnt_base  = new_message ? '0 : count_q;
    pack_next = new_message ? '0 : pack_q;
    cnt_after = cnt_base;
    if (valid_in) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (cnt_base == CW'(i)) pack_next[8*i +: 8] = data_in;
      end
      cnt_after = cnt_base + 1'b1;
    end
    full_lane = valid_in && (cnt_base == CW'(WORD_BYTES - 1));
    push      = full_lane || end_message;
    count_d   = push ? '0 : cnt_after;
    pack_d    = push ? '0 : pack_next;
  end

  // A push into a full FIFO is only dropped when no pop frees a slot that cycle
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    pop        = (level_q != '0) && word_ready;
    do_push    = push && ((level_q != LW'(FIFO_DEPTH)) || pop);
    overflow_d = overflow_q | (push & ~do_push);
    if (do_push) begin
      mem_d[wr_ptr_q] = {pack_next, cnt_after, end_message};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q    <= '0;
      pack_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q    <= count_d;
      pack_q     <= pack_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
    end
  end

  always_comb begin
    head       = mem_q[rd_ptr_q];
    word_valid = (level_q != '0);
    word_out   = word_valid ? head.data  : '0;
    word_bytes = word_valid ? head.bytes : '0;
    word_last  = word_valid ? head.last  : 1'b0;
    fifo_level = level_q;
    overflow   = overflow_q;
  end

endmodule
